// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM:
// state codes, opcode/funct values, datapath select encodings and the per-state control word.
package mc_pkg;

    localparam int STATE_W = 4;

    localparam logic [3:0] S_IF  = 4'd0;
    localparam logic [3:0] S_ID  = 4'd1;
    localparam logic [3:0] S_MA  = 4'd2;
    localparam logic [3:0] S_MRD = 4'd3;
    localparam logic [3:0] S_MWB = 4'd4;
    localparam logic [3:0] S_MWR = 4'd5;
    localparam logic [3:0] S_REX = 4'd6;
    localparam logic [3:0] S_RWB = 4'd7;
    localparam logic [3:0] S_IEX = 4'd8;
    localparam logic [3:0] S_IWB = 4'd9;
    localparam logic [3:0] S_BR  = 4'd10;
    localparam logic [3:0] S_BRT = 4'd11;
    localparam logic [3:0] S_JMP = 4'd12;
    localparam logic [3:0] S_RST = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_MEM,
        CLS_ADDI,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } inst_class_t;

    typedef struct packed {
        logic       write_pc;
        logic [1:0] pcsource;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       write_ir;
        logic       reg_write;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       retire;
    } ctrl_t;

    // Control word a state drives for its whole duration; decode-dependent pulses are added in the FSM.
    function automatic ctrl_t state_ctrl(input logic [3:0] st, input logic [2:0] rex_aluop);
        ctrl_t c;
        c = '0;
        case (st)
            S_IF: begin
                c.mem_read = 1'b1;
                c.write_ir = 1'b1;
                c.alusrcb  = SRCB_FOUR;
                c.aluop    = ALU_ADD;
                c.pcsource = PCSRC_ALU;
                c.write_pc = 1'b1;
            end
            S_ID: begin
                c.alusrcb = SRCB_BRANCH;
                c.aluop   = ALU_ADD;
            end
            S_MA, S_IEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALU_ADD;
            end
            S_MRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MWB: begin
                c.reg_write = 1'b1;
                c.memtoreg  = 1'b1;
                c.retire    = 1'b1;
            end
            S_MWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.retire    = 1'b1;
            end
            S_REX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                c.aluop   = rex_aluop;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.regdst    = 1'b1;
                c.retire    = 1'b1;
            end
            S_IWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                c.aluop   = ALU_SUB;
            end
            S_BRT: begin
                c.write_pc = 1'b1;
                c.pcsource = PCSRC_ALUOUT;
                c.retire   = 1'b1;
            end
            S_JMP: begin
                c.write_pc = 1'b1;
                c.pcsource = PCSRC_JUMP;
                c.retire   = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decode: instruction class, R-type ALU operation and the illegal flag.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output inst_class_t inst_class,
    output logic [2:0]  r_aluop,
    output logic        illegal,
    output logic        is_lw,
    output logic        is_bne
);

    always_comb begin
        inst_class = CLS_ILLEGAL;
        r_aluop    = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin inst_class = CLS_R; r_aluop = ALU_ADD; end
                    FN_SUB: begin inst_class = CLS_R; r_aluop = ALU_SUB; end
                    FN_AND: begin inst_class = CLS_R; r_aluop = ALU_AND; end
                    FN_OR:  begin inst_class = CLS_R; r_aluop = ALU_OR;  end
                    FN_SLT: begin inst_class = CLS_R; r_aluop = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_LW, OP_SW:   inst_class = CLS_MEM;
            OP_ADDI:        inst_class = CLS_ADDI;
            OP_BEQ, OP_BNE: inst_class = CLS_BRANCH;
            OP_J:           inst_class = CLS_JUMP;
            default: ;
        endcase
    end

    assign illegal = (inst_class == CLS_ILLEGAL);
    assign is_lw   = (opcode == OP_LW);
    assign is_bne  = (opcode == OP_BNE);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and drives registered
// datapath enables and mux selects computed from the state being entered.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               write_pc,
    output logic [1:0]         pcsource,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               write_ir,
    output logic               reg_write,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [2:0]         aluop,
    output logic [STATE_W-1:0] state,
    output logic               retire,
    output logic               illegal
);

    logic [3:0]  state_q;
    logic [3:0]  next_state;
    ctrl_t       ctrl_q;
    logic        br_bne_q;
    logic        taken;

    inst_class_t dec_class;
    logic [2:0]  dec_aluop;
    logic        dec_illegal;
    logic        dec_is_lw;
    logic        dec_is_bne;

    mc_ctrl_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .inst_class (dec_class),
        .r_aluop    (dec_aluop),
        .illegal    (dec_illegal),
        .is_lw      (dec_is_lw),
        .is_bne     (dec_is_bne)
    );

    // The branch sense is captured in ID so the IR need not stay stable through BR.
    assign taken = zero ^ br_bne_q;

    always_comb begin
        next_state = S_IF;
        case (state_q)
            S_RST: next_state = S_IF;
            S_IF:  next_state = S_ID;
            S_ID: begin
                case (dec_class)
                    CLS_R:      next_state = S_REX;
                    CLS_MEM:    next_state = S_MA;
                    CLS_ADDI:   next_state = S_IEX;
                    CLS_BRANCH: next_state = S_BR;
                    CLS_JUMP:   next_state = S_JMP;
                    default:    next_state = S_IF;
                endcase
            end
            S_MA:  next_state = dec_is_lw ? S_MRD : S_MWR;
            S_MRD: next_state = S_MWB;
            S_REX: next_state = S_RWB;
            S_IEX: next_state = S_IWB;
            S_BR:  next_state = taken ? S_BRT : S_IF;
            default: next_state = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RST;
            ctrl_q   <= '0;
            br_bne_q <= 1'b0;
        end else begin
            state_q <= next_state;
            ctrl_q  <= state_ctrl(next_state, dec_aluop);
            if (state_q == S_ID) begin
                br_bne_q <= dec_is_bne;
            end
        end
    end

    assign write_pc  = ctrl_q.write_pc;
    assign pcsource  = ctrl_q.pcsource;
    assign iord      = ctrl_q.iord;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign write_ir  = ctrl_q.write_ir;
    assign reg_write = ctrl_q.reg_write;
    assign regdst    = ctrl_q.regdst;
    assign memtoreg  = ctrl_q.memtoreg;
    assign alusrca   = ctrl_q.alusrca;
    assign alusrcb   = ctrl_q.alusrcb;
    assign aluop     = ctrl_q.aluop;
    assign state     = STATE_W'(state_q);

    // The ID illegal pulse and the BR not-taken retire depend on the IR and on zero within the
    // current cycle, so they are formed from the registered state rather than registered themselves.
    assign illegal = (state_q == S_ID) && dec_illegal;
    assign retire  = ctrl_q.retire | illegal | ((state_q == S_BR) && !taken);

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl against an instruction-level reference model.
module tb_mc_ctrl;

    localparam int ST_IF = 0, ST_ID = 1, ST_MA = 2, ST_MRD = 3, ST_MWB = 4, ST_MWR = 5;
    localparam int ST_REX = 6, ST_RWB = 7, ST_IEX = 8, ST_IWB = 9, ST_BR = 10, ST_BRT = 11;
    localparam int ST_JMP = 12, ST_RST = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       write_pc;
    logic [1:0] pcsource;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       write_ir;
    logic       reg_write;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [3:0] state;
    logic       retire;
    logic       illegal;
    logic [17:0] obs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.STATE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .write_pc  (write_pc),
        .pcsource  (pcsource),
        .iord      (iord),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .write_ir  (write_ir),
        .reg_write (reg_write),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .state     (state),
        .retire    (retire),
        .illegal   (illegal)
    );

    assign obs = {write_pc, pcsource, iord, mem_read, mem_write, write_ir, reg_write,
                  regdst, memtoreg, alusrca, alusrcb, aluop, retire, illegal};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] word(input logic wpc, input logic [1:0] pcs, input logic io,
                                         input logic mr, input logic mw, input logic wir,
                                         input logic rw, input logic rd, input logic m2r,
                                         input logic asa, input logic [1:0] asb,
                                         input logic [2:0] op, input logic ret, input logic ill);
        return {wpc, pcs, io, mr, mw, wir, rw, rd, m2r, asa, asb, op, ret, ill};
    endfunction

    // Reference: which instruction does this opcode/funct name, and what R-type ALU op it implies.
    function automatic string classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                fn == 6'b100101 || fn == 6'b101010) return "R";
            return "ILL";
        end
        if (op == 6'b100011) return "LW";
        if (op == 6'b101011) return "SW";
        if (op == 6'b001000) return "ADDI";
        if (op == 6'b000100) return "BEQ";
        if (op == 6'b000101) return "BNE";
        if (op == 6'b000010) return "J";
        return "ILL";
    endfunction

    function automatic logic [2:0] r_op(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b001;
            6'b100100: return 3'b010;
            6'b100101: return 3'b011;
            6'b101010: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic logic [17:0] expect_word(input int st, input logic ill, input logic not_taken,
                                                input logic [2:0] rop);
        case (st)
            ST_IF:  return word(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 0, 0);
            ST_ID:  return word(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, ill, ill);
            ST_MA:  return word(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0, 0);
            ST_MRD: return word(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
            ST_MWB: return word(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 1, 0);
            ST_MWR: return word(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0);
            ST_REX: return word(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, rop, 0, 0);
            ST_RWB: return word(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 1, 0);
            ST_IEX: return word(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0, 0);
            ST_IWB: return word(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 1, 0);
            ST_BR:  return word(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, not_taken, 0);
            ST_BRT: return word(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0);
            ST_JMP: return word(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0);
            default: return '0;
        endcase
    endfunction

    // Runs one instruction from IF; if rst_at >= 0, rst is raised in that cycle and the run stops.
    task automatic applyStimulus(input string name, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int rst_at);
        int seq[$];
        string kind;
        logic taken;
        logic ill;
        kind  = classify(op, fn);
        taken = (kind == "BEQ") ? z : !z;
        ill   = (kind == "ILL");
        case (kind)
            "R":    seq = '{ST_IF, ST_ID, ST_REX, ST_RWB};
            "LW":   seq = '{ST_IF, ST_ID, ST_MA, ST_MRD, ST_MWB};
            "SW":   seq = '{ST_IF, ST_ID, ST_MA, ST_MWR};
            "ADDI": seq = '{ST_IF, ST_ID, ST_IEX, ST_IWB};
            "J":    seq = '{ST_IF, ST_ID, ST_JMP};
            "BEQ", "BNE": seq = taken ? '{ST_IF, ST_ID, ST_BR, ST_BRT} : '{ST_IF, ST_ID, ST_BR};
            default: seq = '{ST_IF, ST_ID};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == ST_ID || seq[i] == ST_MA) begin
                opcode = op;
                funct  = fn;
            end else begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            zero = (seq[i] == ST_BR) ? z : 1'($urandom);
            if (i == rst_at) rst = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("%s c%0d state", name, i), 32'(state), 32'(seq[i]));
            checkOutput($sformatf("%s c%0d ctrl", name, i), 32'(obs),
                        32'(expect_word(seq[i], ill, !taken, r_op(fn))));
            checkOutput($sformatf("%s c%0d rd_wr_excl", name, i), 32'(mem_read & mem_write), 0);
            @(posedge clk);
            #1;
            if (i == rst_at) return;
        end
    endtask

    task automatic check_reset_cycle(input string name);
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        zero   = 1'($urandom);
        @(negedge clk);
        checkOutput({name, " state"}, 32'(state), ST_RST);
        checkOutput({name, " ctrl"}, 32'(obs), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] r_functs [5];
        string kind;
        int pick;
        r_functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        rst = 1'b1;
        opcode = '0;
        funct = '0;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_cycle("por0");
        rst = 1'b0;
        check_reset_cycle("por_release");

        applyStimulus("sub", 6'b000000, 6'b100010, 1'b0, -1);
        applyStimulus("lw", 6'b100011, 6'b000000, 1'b0, -1);
        applyStimulus("sw", 6'b101011, 6'b010101, 1'b1, -1);
        applyStimulus("beq_t", 6'b000100, 6'b000000, 1'b1, -1);
        applyStimulus("beq_nt", 6'b000100, 6'b000000, 1'b0, -1);
        applyStimulus("bne_t", 6'b000101, 6'b000000, 1'b0, -1);
        applyStimulus("bne_nt", 6'b000101, 6'b000000, 1'b1, -1);
        applyStimulus("j", 6'b000010, 6'b111111, 1'b0, -1);
        applyStimulus("ill_op", 6'b111111, 6'b100000, 1'b0, -1);
        applyStimulus("ill_fn", 6'b000000, 6'b000000, 1'b0, -1);
        applyStimulus("addi", 6'b001000, 6'b000000, 1'b0, -1);
        applyStimulus("slt", 6'b000000, 6'b101010, 1'b0, -1);

        // Reset held for three cycles starting in MRD of a load.
        applyStimulus("lw_rst", 6'b100011, 6'b000000, 1'b0, 3);
        check_reset_cycle("mid_rst1");
        check_reset_cycle("mid_rst2");
        rst = 1'b0;
        check_reset_cycle("mid_release");
        applyStimulus("after_rst", 6'b000000, 6'b100101, 1'b0, -1);

        for (int n = 0; n < 80; n++) begin
            pick = $urandom_range(0, 7);
            fn = 6'($urandom);
            case (pick)
                0: begin op = 6'b000000; fn = r_functs[$urandom_range(0, 4)]; end
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b001000;
                4: op = 6'b000100;
                5: op = 6'b000101;
                6: op = 6'b000010;
                default: begin
                    do begin
                        op = ($urandom_range(0, 1) == 0) ? 6'b000000 : 6'($urandom);
                        fn = 6'($urandom);
                        kind = classify(op, fn);
                    end while (kind != "ILL");
                end
            endcase
            applyStimulus($sformatf("rnd%0d", n), op, fn, 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
